// File: rtl/fb_rxmac_p.sv
// FreeDM bus receive MAC: preamble/SoC decode, per-type payload parsing and
// CRC-8 frame check; state and received pulses change only on CRC-good frames.
module fb_rxmac_p #(
  parameter int DATA_BYTES  = 2,
  parameter int MAX_SLAVES  = 16,
  parameter int HDR_NIBBLES = 4,
  parameter int SUM_W       = 16,
  parameter int ADDR_W      = 8
) (
  input  logic                     MRxClk,
  input  logic                     Reset,
  input  logic                     MRxDV,
  input  logic [3:0]               MRxD,
  output logic [7:0]               RxData,
  output logic                     RxValid,
  output logic [ADDR_W-1:0]        RxAddr,
  output logic [7:0]               SlaveCount,
  output logic [SUM_W-1:0]         DelaySum,
  output logic [4*HDR_NIBBLES-1:0] RxHeader,
  output logic                     NumbFrameReceived,
  output logic                     DistFrameReceived,
  output logic                     DelayFrameReceived,
  output logic                     DelayDistFrameReceived,
  output logic                     DataFrameReceived,
  output logic                     CrcError,
  output logic                     FrameAbort,
  output logic                     StateIdle
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, CRC, DROP} state_t;
  typedef enum logic [2:0] {F_NUMB, F_DIST, F_DELAY, F_DDIST, F_DATA} ftype_t;

  localparam logic [15:0] HDR16 = 16'(HDR_NIBBLES);
  localparam logic [7:0]  MAX8  = 8'(MAX_SLAVES);

  state_t                   state_q, state_d;
  ftype_t                   ftype_q, ftype_d, soc_type;
  logic [15:0]              cnt_q, cnt_d, plen_q, plen_d, soc_len, sc16;
  logic [7:0]               crc_q, crc_d, num_q, num_d, byte_val;
  logic [3:0]               low_q, low_d, crc_lo_q, crc_lo_d;
  logic                     crc_half_q, crc_half_d, soc_ok;
  logic [4*HDR_NIBBLES-1:0] hdr_q, hdr_d, rx_header_q, rx_header_d;
  logic [ADDR_W-1:0]        addr_q, addr_d, rx_addr_q, rx_addr_d;
  logic [SUM_W-1:0]         sum_q, sum_d, delay_sum_q, delay_sum_d;
  logic [7:0]               rx_data_q, rx_data_d, slave_count_q, slave_count_d;
  logic                     rx_valid_q, rx_valid_d, state_idle_q, state_idle_d;
  logic [6:0]               pulse_q, pulse_d;

  // MRxD[0] enters the shift register first
  function automatic logic [7:0] crc_nib(input logic [7:0] c, input logic [3:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction

  always_comb begin
    sc16     = {8'd0, slave_count_q};
    soc_ok   = 1'b1;
    soc_type = F_NUMB;
    soc_len  = 16'd2;
    case (MRxD)
      4'h2: begin soc_type = F_DDIST; soc_len = HDR16; end
      4'h3: begin soc_type = F_DELAY; soc_len = HDR16 + (sc16 << 1); end
      4'h4: begin soc_type = F_DIST;  soc_len = HDR16; end
      4'h6: begin soc_type = F_NUMB;  soc_len = 16'd2; end
      4'h7: begin soc_type = F_DATA;  soc_len = HDR16 + 16'(2 * DATA_BYTES) * sc16; end
      default: soc_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ftype_d       = ftype_q;
    cnt_d         = cnt_q;
    plen_d        = plen_q;
    crc_d         = crc_q;
    num_d         = num_q;
    low_d         = low_q;
    crc_lo_d      = crc_lo_q;
    crc_half_d    = crc_half_q;
    hdr_d         = hdr_q;
    addr_d        = addr_q;
    sum_d         = sum_q;
    rx_header_d   = rx_header_q;
    delay_sum_d   = delay_sum_q;
    slave_count_d = slave_count_q;
    rx_data_d     = 8'd0;
    rx_valid_d    = 1'b0;
    rx_addr_d     = '0;
    pulse_d       = 7'd0;
    byte_val      = {MRxD, low_q};
    case (state_q)
      IDLE: if (MRxDV) state_d = (MRxD == 4'h5) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!MRxDV) state_d = IDLE;
        else if (MRxD == 4'h5) state_d = PREAMBLE;
        else if (soc_ok) begin
          state_d = PAYLOAD;
          cnt_d   = 16'd0;
          crc_d   = crc_nib(8'hFF, MRxD);
          ftype_d = soc_type;
          plen_d  = soc_len;
          addr_d  = '0;
          sum_d   = '0;
        end else state_d = DROP;
      end
      PAYLOAD: begin
        if (!MRxDV) begin
          state_d    = IDLE;
          pulse_d[6] = 1'b1;
        end else begin
          crc_d = crc_nib(crc_q, MRxD);
          cnt_d = cnt_q + 16'd1;
          if (!cnt_q[0]) low_d = MRxD;
          for (int i = 0; i < HDR_NIBBLES; i++)
            if (cnt_q == 16'(i)) hdr_d[4*i +: 4] = MRxD;
          if (cnt_q[0] && ftype_q == F_NUMB) num_d = byte_val;
          if (cnt_q[0] && cnt_q >= HDR16 && ftype_q == F_DATA) begin
            rx_valid_d = 1'b1;
            rx_data_d  = byte_val;
            rx_addr_d  = addr_q;
            addr_d     = addr_q + 1'b1;
          end
          if (cnt_q[0] && cnt_q >= HDR16 && ftype_q == F_DELAY)
            sum_d = sum_q + SUM_W'(byte_val);
          if (cnt_q == plen_q - 16'd1) begin
            state_d    = CRC;
            crc_half_d = 1'b0;
          end
        end
      end
      CRC: begin
        if (!MRxDV) begin
          state_d    = IDLE;
          pulse_d[6] = 1'b1;
        end else if (!crc_half_q) begin
          crc_lo_d   = MRxD;
          crc_half_d = 1'b1;
        end else begin
          state_d = DROP;
          // Transmitted CRC is the complement of the running register, low nibble first
          if ({MRxD, crc_lo_q} == ~crc_q) begin
            pulse_d[ftype_q] = 1'b1;
            if (ftype_q == F_NUMB) slave_count_d = (num_q > MAX8) ? MAX8 : num_q;
            else rx_header_d = hdr_q;
            if (ftype_q == F_DELAY) delay_sum_d = sum_q;
          end else pulse_d[5] = 1'b1;
        end
      end
      DROP: if (!MRxDV) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    state_idle_d = (state_d == IDLE);
  end

  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      ftype_q       <= F_NUMB;
      cnt_q         <= '0;
      plen_q        <= '0;
      crc_q         <= '0;
      num_q         <= '0;
      low_q         <= '0;
      crc_lo_q      <= '0;
      crc_half_q    <= 1'b0;
      hdr_q         <= '0;
      addr_q        <= '0;
      sum_q         <= '0;
      rx_header_q   <= '0;
      delay_sum_q   <= '0;
      slave_count_q <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_addr_q     <= '0;
      pulse_q       <= '0;
      state_idle_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ftype_q       <= ftype_d;
      cnt_q         <= cnt_d;
      plen_q        <= plen_d;
      crc_q         <= crc_d;
      num_q         <= num_d;
      low_q         <= low_d;
      crc_lo_q      <= crc_lo_d;
      crc_half_q    <= crc_half_d;
      hdr_q         <= hdr_d;
      addr_q        <= addr_d;
      sum_q         <= sum_d;
      rx_header_q   <= rx_header_d;
      delay_sum_q   <= delay_sum_d;
      slave_count_q <= slave_count_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_addr_q     <= rx_addr_d;
      pulse_q       <= pulse_d;
      state_idle_q  <= state_idle_d;
    end
  end

  assign RxData                 = rx_data_q;
  assign RxValid                = rx_valid_q;
  assign RxAddr                 = rx_addr_q;
  assign SlaveCount             = slave_count_q;
  assign DelaySum               = delay_sum_q;
  assign RxHeader               = rx_header_q;
  assign NumbFrameReceived      = pulse_q[0];
  assign DistFrameReceived      = pulse_q[1];
  assign DelayFrameReceived     = pulse_q[2];
  assign DelayDistFrameReceived = pulse_q[3];
  assign DataFrameReceived      = pulse_q[4];
  assign CrcError               = pulse_q[5];
  assign FrameAbort             = pulse_q[6];
  assign StateIdle              = state_idle_q;

endmodule

// File: tb/tb_fb_rxmac_p.sv
// Directed bench for fb_rxmac_p: frames built from nibble lists with a CRC-8
// reference; a negedge monitor tallies pulses and captured payload bytes.
module tb_fb_rxmac_p;
  logic        MRxClk = 1'b0;
  logic        Reset;
  logic        MRxDV;
  logic [3:0]  MRxD;
  logic [7:0]  RxData;
  logic        RxValid;
  logic [7:0]  RxAddr;
  logic [7:0]  SlaveCount;
  logic [15:0] DelaySum;
  logic [15:0] RxHeader;
  logic        NumbFrameReceived, DistFrameReceived, DelayFrameReceived;
  logic        DelayDistFrameReceived, DataFrameReceived, CrcError, FrameAbort, StateIdle;

  fb_rxmac_p dut (
    .MRxClk(MRxClk), .Reset(Reset), .MRxDV(MRxDV), .MRxD(MRxD),
    .RxData(RxData), .RxValid(RxValid), .RxAddr(RxAddr),
    .SlaveCount(SlaveCount), .DelaySum(DelaySum), .RxHeader(RxHeader),
    .NumbFrameReceived(NumbFrameReceived), .DistFrameReceived(DistFrameReceived),
    .DelayFrameReceived(DelayFrameReceived), .DelayDistFrameReceived(DelayDistFrameReceived),
    .DataFrameReceived(DataFrameReceived), .CrcError(CrcError),
    .FrameAbort(FrameAbort), .StateIdle(StateIdle)
  );

  always #5 MRxClk = ~MRxClk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [7];
  int pulse_base [7];
  int multi_cnt = 0;
  int leak_cnt = 0;
  int valid_cnt = 0;
  int valid_base = 0;
  logic [7:0] v_data [64];
  logic [7:0] v_addr [64];
  logic [3:0] pay [$];
  logic [6:0] pulses;
  logic       any_out;

  assign pulses = {FrameAbort, CrcError, DataFrameReceived, DelayDistFrameReceived,
                   DelayFrameReceived, DistFrameReceived, NumbFrameReceived};
  assign any_out = |{RxData, RxValid, RxAddr, SlaveCount, DelaySum, RxHeader, pulses, StateIdle};

  // Output monitor: counts each pulse and records every strobed byte
  always @(negedge MRxClk) begin
    for (int i = 0; i < 7; i++) if (pulses[i]) pulse_cnt[i]++;
    if ($countones(pulses) > 1) multi_cnt++;
    if (!RxValid && RxData != 8'd0) leak_cnt++;
    if (RxValid && valid_cnt < 64) begin
      v_data[valid_cnt] = RxData;
      v_addr[valid_cnt] = RxAddr;
      valid_cnt++;
    end
  end

  function automatic logic [7:0] crcNib(input logic [7:0] c, input logic [3:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h07;
      else r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic int delta(input int i);
    return pulse_cnt[i] - pulse_base[i];
  endfunction

  task automatic snap();
    for (int i = 0; i < 7; i++) pulse_base[i] = pulse_cnt[i];
    valid_base = valid_cnt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveNibble(input logic dv, input logic [3:0] d);
    @(negedge MRxClk);
    MRxDV = dv;
    MRxD  = d;
  endtask

  // Sends preamble, SoC, the pay queue and CRC; abort_after >= 0 drops MRxDV early
  task automatic applyStimulus(input logic [3:0] soc, input logic [3:0] flip, input int abort_after);
    logic [7:0] crc;
    int n;
    snap();
    n = (abort_after >= 0) ? abort_after : pay.size();
    crc = 8'hFF;
    repeat (3) driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, soc);
    crc = crcNib(crc, soc);
    for (int i = 0; i < n; i++) begin
      driveNibble(1'b1, pay[i]);
      crc = crcNib(crc, pay[i]);
    end
    if (abort_after < 0) begin
      driveNibble(1'b1, (~crc[3:0]) ^ flip);
      driveNibble(1'b1, ~crc[7:4]);
    end
    repeat (4) driveNibble(1'b0, 4'h0);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    MRxDV = 1'b0;
    MRxD  = 4'h0;
    repeat (2) @(negedge MRxClk);
    #1 checkOutput("reset_outputs_zero", {31'd0, any_out}, 32'd0);
    @(negedge MRxClk);
    Reset = 1'b0;
    driveNibble(1'b0, 4'h0);
    #1 checkOutput("idle_after_reset", {31'd0, StateIdle}, 32'd1);

    pay = {4'h3, 4'h0};
    applyStimulus(4'h6, 4'h0, -1);
    checkOutput("numb_pulse", delta(0), 1);
    checkOutput("slave_count_3", {24'd0, SlaveCount}, 32'd3);

    pay = {4'h1, 4'h2, 4'h3, 4'h4};
    for (int b = 1; b <= 6; b++) begin
      pay.push_back(4'(b));
      pay.push_back(4'h1);
    end
    applyStimulus(4'h7, 4'h0, -1);
    checkOutput("data_valid_count", valid_cnt - valid_base, 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("data_byte", {24'd0, v_data[valid_base + k]}, 32'h11 + 32'(k));
      checkOutput("data_addr", {24'd0, v_addr[valid_base + k]}, 32'(k));
    end
    checkOutput("data_pulse", delta(4), 1);
    checkOutput("data_header", {16'd0, RxHeader}, 32'h4321);

    pay = {4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2, 4'hF, 4'hF};
    applyStimulus(4'h3, 4'h0, -1);
    checkOutput("delay_pulse", delta(2), 1);
    checkOutput("delay_sum", {16'd0, DelaySum}, 32'h012F);
    checkOutput("delay_no_valid", valid_cnt - valid_base, 0);
    checkOutput("delay_header", {16'd0, RxHeader}, 32'h8765);

    pay = {4'h9, 4'h9, 4'h9, 4'h9, 4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0};
    applyStimulus(4'h3, 4'h1, -1);
    checkOutput("bad_crc_error", delta(5), 1);
    checkOutput("bad_crc_no_type", delta(2), 0);
    checkOutput("bad_crc_sum_kept", {16'd0, DelaySum}, 32'h012F);
    checkOutput("bad_crc_header_kept", {16'd0, RxHeader}, 32'h8765);

    pay = {4'h1, 4'h2, 4'h3, 4'h4};
    for (int b = 1; b <= 6; b++) begin
      pay.push_back(4'(b));
      pay.push_back(4'h2);
    end
    applyStimulus(4'h7, 4'h0, 10);
    checkOutput("abort_pulse", delta(6), 1);
    checkOutput("abort_no_type", delta(4), 0);
    checkOutput("abort_valid_count", valid_cnt - valid_base, 3);
    checkOutput("abort_idle", {31'd0, StateIdle}, 32'd1);

    pay = {4'hA, 4'hB, 4'hC, 4'hD};
    applyStimulus(4'h4, 4'h0, -1);
    checkOutput("dist_pulse", delta(1), 1);
    checkOutput("dist_header", {16'd0, RxHeader}, 32'hDCBA);
    pay = {4'h1, 4'h0, 4'h0, 4'hF};
    applyStimulus(4'h2, 4'h0, -1);
    checkOutput("ddist_pulse", delta(3), 1);
    checkOutput("ddist_header", {16'd0, RxHeader}, 32'hF001);

    snap();
    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'h9);
    driveNibble(1'b1, 4'h5);
    #1 checkOutput("bad_soc_not_idle", {31'd0, StateIdle}, 32'd0);
    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'h6);
    driveNibble(1'b1, 4'h3);
    driveNibble(1'b1, 4'h0);
    #1 checkOutput("drop_still_busy", {31'd0, StateIdle}, 32'd0);
    repeat (3) driveNibble(1'b0, 4'h0);
    #1 checkOutput("drop_no_pulses",
                   delta(0) + delta(1) + delta(2) + delta(3) + delta(4) + delta(5) + delta(6), 0);
    checkOutput("drop_back_idle", {31'd0, StateIdle}, 32'd1);

    pay = {4'h0, 4'h4};
    applyStimulus(4'h6, 4'h0, -1);
    checkOutput("numb_saturate", {24'd0, SlaveCount}, 32'd16);

    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'h5);
    driveNibble(1'b1, 4'h7);
    driveNibble(1'b1, 4'h1);
    driveNibble(1'b1, 4'h2);
    #2 Reset = 1'b1;
    #1 checkOutput("midframe_reset_zero", {31'd0, any_out}, 32'd0);
    checkOutput("midframe_reset_sc", {24'd0, SlaveCount}, 32'd0);
    @(negedge MRxClk);
    MRxDV = 1'b0;
    Reset = 1'b0;
    driveNibble(1'b0, 4'h0);
    #1 checkOutput("post_reset_idle", {31'd0, StateIdle}, 32'd1);

    pay = {4'h5, 4'h6, 4'h7, 4'h8};
    applyStimulus(4'h3, 4'h0, -1);
    checkOutput("sc0_delay_pulse", delta(2), 1);
    checkOutput("sc0_delay_crc_ok", delta(5), 0);
    checkOutput("sc0_delay_sum", {16'd0, DelaySum}, 32'd0);
    checkOutput("sc0_header", {16'd0, RxHeader}, 32'h8765);

    checkOutput("pulses_exclusive", multi_cnt, 0);
    checkOutput("rxdata_zero_when_idle", leak_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
